// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } bcd_state_t;

  // Minimum decimal digits for a w-bit unsigned value: ceil(w * log10(2)).
  // 30103/100000 slightly overestimates log10(2); the error stays below one
  // digit boundary for every operand width this block is realistically built for.
  function automatic int digits_for(input int w);
    return (w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// One BCD digit correction stage of the shift-and-add-3 algorithm.
module bcd_add3_digit
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  // Modulo-16 add; digits never exceed 9 before correction when DIGITS is sized correctly.
  assign dout = (din >= 4'd5) ? (din + 4'd3) : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter: one shift-and-add-3 step per clock,
// valid/ready on both sides, optional two's-complement input handling.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3,
  parameter bit SIGNED = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BIN_W-1:0]              bin_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                          sign_out
);

  localparam int CNT_W = $clog2(BIN_W);
  localparam int BCD_W = BCD_DIGIT_W * DIGITS;

  if (DIGITS < digits_for(BIN_W)) begin : g_bad_digits
    $error("bin2bcd_seq: DIGITS=%0d too small for BIN_W=%0d", DIGITS, BIN_W);
  end

  bcd_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   mag_q, mag_d;
  logic [BCD_W-1:0]   dig_q, dig_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               sign_q, sign_d;
  logic [BCD_W-1:0]   adj;
  logic               neg;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    bcd_add3_digit u_add3 (
      .din  (dig_q[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout (adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    dig_d   = dig_q;
    bcd_d   = bcd_q;
    sign_d  = sign_q;
    neg     = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          neg     = SIGNED && bin_in[BIN_W-1];
          // Negating the most-negative value wraps back to 2^(BIN_W-1), which is the magnitude we want.
          mag_d   = neg ? -bin_in : bin_in;
          sign_d  = neg;
          dig_d   = '0;
          cnt_d   = CNT_W'(BIN_W - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {dig_d, mag_d} = {adj[BCD_W-2:0], mag_q, 1'b0};
        if (cnt_q == '0) begin
          bcd_d   = {adj[BCD_W-2:0], mag_q[BIN_W-1]};
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mag_q   <= '0;
      dig_q   <= '0;
      bcd_q   <= '0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
      dig_q   <= dig_d;
      bcd_q   <= bcd_d;
      sign_q  <= sign_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign bcd_out   = bcd_q;
  assign sign_out  = sign_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: 8-bit unsigned, 8-bit signed and 16-bit unsigned instances.
module tb_bin2bcd_seq;

  logic clk;
  logic rst_n;

  logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, sign_a;
  logic [7:0]  bin_a;
  logic [11:0] bcd_a;

  logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, sign_b;
  logic [7:0]  bin_b;
  logic [11:0] bcd_b;

  logic        in_valid_c, in_ready_c, out_valid_c, out_ready_c, sign_c;
  logic [15:0] bin_c;
  logic [19:0] bcd_c;

  int checks = 0;
  int errors = 0;

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3), .SIGNED(1'b0)) u_dut_u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a), .bin_in(bin_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .bcd_out(bcd_a), .sign_out(sign_a)
  );

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3), .SIGNED(1'b1)) u_dut_s8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b), .bin_in(bin_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .bcd_out(bcd_b), .sign_out(sign_b)
  );

  bin2bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED(1'b0)) u_dut_u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_c), .in_ready(in_ready_c), .bin_in(bin_c),
    .out_valid(out_valid_c), .out_ready(out_ready_c), .bcd_out(bcd_c), .sign_out(sign_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic [15:0] val);
    case (sel)
      0: begin in_valid_a = v; bin_a = val[7:0]; end
      1: begin in_valid_b = v; bin_b = val[7:0]; end
      default: begin in_valid_c = v; bin_c = val; end
    endcase
  endtask

  task automatic set_ordy(input int sel, input logic v);
    case (sel)
      0: out_ready_a = v;
      1: out_ready_b = v;
      default: out_ready_c = v;
    endcase
  endtask

  function automatic logic get_ov(input int sel);
    case (sel)
      0: return out_valid_a;
      1: return out_valid_b;
      default: return out_valid_c;
    endcase
  endfunction

  function automatic logic get_ir(input int sel);
    case (sel)
      0: return in_ready_a;
      1: return in_ready_b;
      default: return in_ready_c;
    endcase
  endfunction

  function automatic logic [19:0] get_bcd(input int sel);
    case (sel)
      0: return {8'h00, bcd_a};
      1: return {8'h00, bcd_b};
      default: return bcd_c;
    endcase
  endfunction

  function automatic logic get_sgn(input int sel);
    case (sel)
      0: return sign_a;
      1: return sign_b;
      default: return sign_c;
    endcase
  endfunction

  // Decimal digits by division, independent of the shift-and-add-3 structure.
  function automatic logic [19:0] ref_bcd(input int v);
    logic [19:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Called #1 after an edge with the DUT idle. lat counts rising edges from
  // the accepting edge (inclusive) to the edge after which out_valid is seen.
  task automatic convert(input int sel, input logic [15:0] val,
                         output logic [19:0] bcd, output logic sgn, output int lat);
    int  n;
    logic ov;
    check("in_ready_before", 32'(get_ir(sel)), 32'd1);
    drive(sel, 1'b1, val);
    @(posedge clk); #1;
    drive(sel, 1'b0, 16'h0000);
    n  = 1;
    ov = get_ov(sel);
    while (!ov && n < 64) begin
      @(posedge clk); #1;
      n++;
      ov = get_ov(sel);
    end
    check("out_valid_seen", 32'(ov), 32'd1);
    lat = n;
    bcd = get_bcd(sel);
    sgn = get_sgn(sel);
    $display("conv dut%0d in=%0h bcd=%0h sign=%0b lat=%0d", sel, val, bcd, sgn, lat);
    set_ordy(sel, 1'b1);
    @(posedge clk); #1;
    set_ordy(sel, 1'b0);
    check("in_ready_after", 32'(get_ir(sel)), 32'd1);
    check("out_valid_after", 32'(get_ov(sel)), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] bcd;
    logic        sgn;
    int          lat;
    logic        seen;

    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) begin
      drive(s, 1'b0, 16'h0000);
      set_ordy(s, 1'b0);
    end
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      check("rst_in_ready", 32'(get_ir(s)), 32'd1);
      check("rst_out_valid", 32'(get_ov(s)), 32'd0);
      check("rst_bcd", 32'(get_bcd(s)), 32'd0);
      check("rst_sign", 32'(get_sgn(s)), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 8-bit unsigned: full-scale value and latency
    convert(0, 16'd255, bcd, sgn, lat);
    check("u8_255_bcd", 32'(bcd), 32'h255);
    check("u8_255_sign", 32'(sgn), 32'd0);
    check("u8_255_lat", 32'(lat), 32'd9);

    convert(0, 16'd0, bcd, sgn, lat);
    check("u8_0_bcd", 32'(bcd), 32'h000);

    for (int v = 0; v < 256; v++) begin
      convert(0, 16'(v), bcd, sgn, lat);
      check("u8_sweep_bcd", 32'(bcd), 32'(ref_bcd(v)));
    end

    // Backpressure: result held, in_ready low, in_valid ignored while stalled
    drive(0, 1'b1, 16'd42);
    @(posedge clk); #1;
    drive(0, 1'b0, 16'h0000);
    for (int i = 0; i < 20 && !out_valid_a; i++) begin
      @(posedge clk); #1;
    end
    check("bp_out_valid_seen", 32'(out_valid_a), 32'd1);
    for (int i = 0; i < 20; i++) begin
      drive(0, (i % 3) == 0, 16'd77);
      check("bp_out_valid", 32'(out_valid_a), 32'd1);
      check("bp_bcd", 32'(bcd_a), 32'h042);
      check("bp_in_ready", 32'(in_ready_a), 32'd0);
      @(posedge clk); #1;
    end
    drive(0, 1'b0, 16'h0000);
    check("bp_bcd_end", 32'(bcd_a), 32'h042);
    $display("conv dut0 in=2a bcd=%0h held 20 cycles", bcd_a);
    out_ready_a = 1'b1;
    @(posedge clk); #1;
    out_ready_a = 1'b0;
    check("bp_release_in_ready", 32'(in_ready_a), 32'd1);
    check("bp_release_out_valid", 32'(out_valid_a), 32'd0);
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid_a) seen = 1'b1;
    end
    check("bp_no_ghost_accept", 32'(seen), 32'd0);

    // 8-bit signed
    convert(1, 16'h0080, bcd, sgn, lat);
    check("s8_80_bcd", 32'(bcd), 32'h128);
    check("s8_80_sign", 32'(sgn), 32'd1);
    convert(1, 16'h00FF, bcd, sgn, lat);
    check("s8_ff_bcd", 32'(bcd), 32'h001);
    check("s8_ff_sign", 32'(sgn), 32'd1);
    convert(1, 16'h007F, bcd, sgn, lat);
    check("s8_7f_bcd", 32'(bcd), 32'h127);
    check("s8_7f_sign", 32'(sgn), 32'd0);
    convert(1, 16'h00F6, bcd, sgn, lat);
    check("s8_f6_bcd", 32'(bcd), 32'h010);
    check("s8_f6_sign", 32'(sgn), 32'd1);
    convert(1, 16'h0000, bcd, sgn, lat);
    check("s8_00_bcd", 32'(bcd), 32'h000);
    check("s8_00_sign", 32'(sgn), 32'd0);

    // 16-bit unsigned
    convert(2, 16'hFFFF, bcd, sgn, lat);
    check("u16_ffff_bcd", 32'(bcd), 32'h65535);
    check("u16_ffff_lat", 32'(lat), 32'd17);
    convert(2, 16'd10000, bcd, sgn, lat);
    check("u16_10000_bcd", 32'(bcd), 32'h10000);
    convert(2, 16'd9, bcd, sgn, lat);
    check("u16_9_bcd", 32'(bcd), 32'h00009);

    // Reset during the fourth SHIFT cycle aborts the conversion
    convert(0, 16'd123, bcd, sgn, lat);
    check("pre_rst_bcd", 32'(bcd_a), 32'h123);
    drive(0, 1'b1, 16'd200);
    @(posedge clk); #1;
    drive(0, 1'b0, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    check("mid_in_ready", 32'(in_ready_a), 32'd0);
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", 32'(in_ready_a), 32'd1);
    check("abort_out_valid", 32'(out_valid_a), 32'd0);
    check("abort_bcd", 32'(bcd_a), 32'h000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    $display("conv dut0 in=c8 aborted by reset");
    check("post_rst_in_ready", 32'(in_ready_a), 32'd1);
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid_a) seen = 1'b1;
    end
    check("abort_no_out_valid", 32'(seen), 32'd0);
    convert(0, 16'd99, bcd, sgn, lat);
    check("after_rst_99_bcd", 32'(bcd), 32'h099);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
